if_id_register: RTL and testbench
=================================

IF_ID_REGISTER -- requirements
Module: if_id_register

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock, the only clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port instr_in, input, 32 bits: fetched instruction word.
REQ-005 The block SHALL have port pc_plus4_in, input, 32 bits: PC+4 of the fetched instruction.
REQ-006 The block SHALL have port in_valid, input, 1 bit: instr_in/pc_plus4_in hold a real instruction this cycle.
REQ-007 The block SHALL have port stall, input, 1 bit: external hold request.
REQ-008 The block SHALL have port flush, input, 1 bit: discard the held instruction (taken branch/jump).
REQ-009 The block SHALL have port ex_mem_read, input, 1 bit: the instruction in EX is a load.
REQ-010 The block SHALL have port ex_rt, input, 5 bits: destination register of the load in EX.
REQ-011 The block SHALL have port in_ready, output, 1 bit: fetch may advance this cycle.
REQ-012 The block SHALL have port valid_out, output, 1 bit: the held instruction is real, not a bubble.
REQ-013 The block SHALL have port instr_out, output, 32 bits: held instruction.
REQ-014 The block SHALL have port pc_plus4_out, output, 32 bits: held PC+4.
REQ-015 The block SHALL have ports opcode [5:0], rs [4:0], rt [4:0], rd [4:0], shamt [4:0] and funct [5:0], outputs: fields of instr_out (bits 31:26, 25:21, 20:16, 15:11, 10:6 and 5:0).
REQ-016 The block SHALL have port immediate, output, 16 bits: instr_out[15:0], driven straight to the sign-extender immediate input.
REQ-017 The block SHALL have port jump_target, output, 26 bits: instr_out[25:0].
REQ-018 The block SHALL have port load_use_stall, output, 1 bit: load-use hazard detected.

Function
REQ-019 The field outputs (REQ-015 to REQ-017) SHALL be pure slices of the instr_out register, with no extra delay.
REQ-020 uses_rt SHALL be 1 when opcode is 6'h00 (R-type), 6'h04 (beq), 6'h05 (bne) or 6'h2B (sw), and 0 for every other opcode.
REQ-021 load_use_stall SHALL be combinational: valid_out AND ex_mem_read AND (ex_rt != 0) AND ((ex_rt == rs) OR (uses_rt AND ex_rt == rt)).
REQ-022 The internal hold condition SHALL be hold = stall OR load_use_stall, and in_ready SHALL equal NOT hold.
REQ-023 The register update on each rising clk edge SHALL follow this priority: flush > hold > load.
REQ-024 On flush: instr_out SHALL become 32'h0 (NOP), valid_out 0, and pc_plus4_out SHALL be unchanged.
REQ-025 On hold without flush: all registers SHALL keep their values.
REQ-026 On load: instr_out SHALL take instr_in, pc_plus4_out SHALL take pc_plus4_in, and valid_out SHALL take in_valid.
REQ-027 When in_valid=0 on a load: instr_out SHALL become 32'h0 and valid_out 0 (bubble).
REQ-028 Latency SHALL be one cycle from instr_in to instr_out/immediate.
REQ-029 When flush and load_use_stall occur together, flush SHALL win, and load_use_stall SHALL drop the next cycle because valid_out=0.
REQ-030 A NOP (instr 0, rs=rt=0) SHALL never raise load_use_stall, because ex_rt == 0 is excluded.
REQ-031 A hazard SHALL persist while ex_mem_read is held; the stage upstream of EX is responsible for clearing it by inserting an EX bubble.

Reset
REQ-032 While reset_n=0, the block SHALL hold instr_out=0, pc_plus4_out=0 and valid_out=0, independent of clk.
REQ-033 While reset_n=0, every field output SHALL be 0, load_use_stall SHALL be 0 and in_ready SHALL equal NOT stall.
REQ-034 After reset_n deassertion, the first rising edge SHALL perform a normal load.
REQ-035 Reset asserted mid-stall SHALL clear the held instruction with no residue after release.

Verification
REQ-036 The bench SHALL cover load: instr_in=32'h2128FFFC (addi $8,$9,-4), in_valid=1, pc_plus4_in=32'h00400004 -> next cycle opcode=6'h08, rs=9, rt=8, immediate=16'hFFFC, valid_out=1.
REQ-037 The bench SHALL cover stall: hold instr 32'h2128FFFC, assert stall=1 for 3 cycles while instr_in=32'hDEADBEEF -> instr_out stays 32'h2128FFFC, in_ready=0, and loads 32'hDEADBEEF on the first edge after stall drops.
REQ-038 The bench SHALL cover load-use: held instr 32'h01095020 (add $10,$8,$9) with ex_mem_read=1 and ex_rt=8 -> load_use_stall=1 and in_ready=0; with ex_rt=0 -> 0; with ex_rt=9 and a held addi (rs=9) -> 1.
REQ-039 The bench SHALL cover flush priority: flush=1 and stall=1 on the same edge -> instr_out=0, valid_out=0, load_use_stall=0.
REQ-040 The bench SHALL cover bubble: in_valid=0 with instr_in=32'hFFFFFFFF -> instr_out=0, valid_out=0.
REQ-041 The bench SHALL cover reset: reset_n pulsed low between clock edges while a valid instruction is held -> outputs go to 0 immediately, and the first edge after release loads instr_in.

Source files
------------

// File: rtl/if_id_register.sv
// -----------------------------------------------------------------------------
// if_id_register
//
// Pipeline register between the fetch (IF) and decode (ID) stages of a
// MIPS-style five-stage pipeline. It also detects load-use hazards against
// the instruction currently in EX.
//
// Register update priority on each rising clk edge: flush > hold > load.
//   flush : the held instruction becomes a NOP bubble (instr_out = 0,
//           valid_out = 0). pc_plus4_out is left untouched.
//   hold  : stall OR load_use_stall. Every register keeps its value.
//   load  : instr_out/pc_plus4_out/valid_out capture the fetch inputs. When
//           in_valid = 0, the word is forced to 0 so the bubble decodes as
//           a NOP.
//
// Ports
//   clk            in   1  rising-edge clock
//   reset_n        in   1  asynchronous active-low reset
//   instr_in       in  32  fetched instruction word
//   pc_plus4_in    in  32  PC+4 of the fetched instruction
//   in_valid       in   1  fetch inputs carry a real instruction
//   stall          in   1  external hold request
//   flush          in   1  discard the held instruction (taken branch/jump)
//   ex_mem_read    in   1  the instruction in EX is a load
//   ex_rt          in   5  destination register of the load in EX
//   in_ready       out  1  fetch may advance this cycle (NOT hold)
//   valid_out      out  1  the held instruction is real, not a bubble
//   instr_out      out 32  held instruction
//   pc_plus4_out   out 32  held PC+4
//   opcode..funct  out     decoded fields of instr_out
//   immediate      out 16  instr_out[15:0], feeds the sign extender
//   jump_target    out 26  instr_out[25:0]
//   load_use_stall out  1  load-use hazard detected (combinational)
// -----------------------------------------------------------------------------
module if_id_register (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_plus4_in,
   input  logic        in_valid,
   input  logic        stall,
   input  logic        flush,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   output logic        in_ready,
   output logic        valid_out,
   output logic [31:0] instr_out,
   output logic [31:0] pc_plus4_out,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] immediate,
   output logic [25:0] jump_target,
   output logic        load_use_stall
);

   // Opcodes whose rt field is a source operand.
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   logic uses_rt;
   logic hold;

   // Field decode: pure slices of the register, no extra pipeline delay.
   assign opcode      = instr_out[31:26];
   assign rs          = instr_out[25:21];
   assign rt          = instr_out[20:16];
   assign rd          = instr_out[15:11];
   assign shamt       = instr_out[10:6];
   assign funct       = instr_out[5:0];
   assign immediate   = instr_out[15:0];
   assign jump_target = instr_out[25:0];

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      uses_rt = 1'b0;
      unique case (opcode)
         OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: uses_rt = 1'b1;
         default:                         uses_rt = 1'b0;
      endcase
   end

   // $zero is never a real dependency, so ex_rt == 0 is excluded; this also
   // keeps NOPs and bubbles (rs = rt = 0) from ever raising the hazard.
   // The hazard persists while EX keeps ex_mem_read high; clearing it is the
   // job of the logic that inserts the EX bubble.
   assign load_use_stall = valid_out && ex_mem_read && (ex_rt != 5'd0) &&
                           ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));

   assign hold     = stall || load_use_stall;
   assign in_ready = !hold;

   // NOTE: state registers use non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_out    <= NOP_WORD;
         pc_plus4_out <= 32'h0;
         valid_out    <= 1'b0;
      end else if (flush) begin
         // Squash only; the stale PC+4 is harmless behind valid_out = 0.
         instr_out <= NOP_WORD;
         valid_out <= 1'b0;
      end else if (!hold) begin
         instr_out    <= in_valid ? instr_in : NOP_WORD;
         pc_plus4_out <= pc_plus4_in;
         valid_out    <= in_valid;
      end
   end

endmodule

// File: tb/tb_if_id_register.sv
// -----------------------------------------------------------------------------
// tb_if_id_register
//
// Self-checking bench for if_id_register. A behavioural model holds the
// expected pipeline-register contents and derives every output from the
// instruction word with plain arithmetic. Directed steps are followed by a
// randomized run.
// -----------------------------------------------------------------------------
module tb_if_id_register;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] instr_in;
   logic [31:0] pc_plus4_in;
   logic        in_valid;
   logic        stall;
   logic        flush;
   logic        ex_mem_read;
   logic [4:0]  ex_rt;
   logic        in_ready;
   logic        valid_out;
   logic [31:0] instr_out;
   logic [31:0] pc_plus4_out;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] immediate;
   logic [25:0] jump_target;
   logic        load_use_stall;

   if_id_register dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .instr_in       (instr_in),
      .pc_plus4_in    (pc_plus4_in),
      .in_valid       (in_valid),
      .stall          (stall),
      .flush          (flush),
      .ex_mem_read    (ex_mem_read),
      .ex_rt          (ex_rt),
      .in_ready       (in_ready),
      .valid_out      (valid_out),
      .instr_out      (instr_out),
      .pc_plus4_out   (pc_plus4_out),
      .opcode         (opcode),
      .rs             (rs),
      .rt             (rt),
      .rd             (rd),
      .shamt          (shamt),
      .funct          (funct),
      .immediate      (immediate),
      .jump_target    (jump_target),
      .load_use_stall (load_use_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned instr;
      int unsigned pc;
      bit          valid;
   } model_t;

   model_t m;
   int     vectors    = 0;
   int     miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Field of the model's word, by shift and modulo.
   function automatic int unsigned fld(input int unsigned w, input int lsb, input int width);
      return (w >> lsb) % (32'd1 << width);
   endfunction

   // Hazard rule stated directly from the decode semantics.
   function automatic bit exp_hazard(input model_t s, input bit emr, input int unsigned ert);
      int unsigned op;
      bit          reads_rt;
      op       = fld(s.instr, 26, 6);
      reads_rt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
      return s.valid && emr && (ert != 0) &&
             ((ert == fld(s.instr, 21, 5)) || (reads_rt && ert == fld(s.instr, 16, 5)));
   endfunction

   task automatic check_all(input string tag);
      bit hz;
      hz = exp_hazard(m, ex_mem_read, ex_rt);
      check({tag, " instr_out"},    instr_out,    m.instr);
      check({tag, " pc_plus4_out"}, pc_plus4_out, m.pc);
      check({tag, " valid_out"},    32'(valid_out), 32'(m.valid));
      check({tag, " opcode"},       32'(opcode),  fld(m.instr, 26, 6));
      check({tag, " rs"},           32'(rs),      fld(m.instr, 21, 5));
      check({tag, " rt"},           32'(rt),      fld(m.instr, 16, 5));
      check({tag, " rd"},           32'(rd),      fld(m.instr, 11, 5));
      check({tag, " shamt"},        32'(shamt),   fld(m.instr, 6, 5));
      check({tag, " funct"},        32'(funct),   fld(m.instr, 0, 6));
      check({tag, " immediate"},    32'(immediate),   fld(m.instr, 0, 16));
      check({tag, " jump_target"},  32'(jump_target), fld(m.instr, 0, 26));
      check({tag, " load_use_stall"}, 32'(load_use_stall), 32'(hz));
      check({tag, " in_ready"},     32'(in_ready), 32'(!(stall || hz)));
   endtask

   // Drive one cycle's inputs, check before and after the next rising edge.
   task automatic apply(input logic [31:0] i, input logic [31:0] p, input bit v,
                        input bit st, input bit fl, input bit emr,
                        input logic [4:0] ert, input string tag);
      model_t nm;
      instr_in    = i;
      pc_plus4_in = p;
      in_valid    = v;
      stall       = st;
      flush       = fl;
      ex_mem_read = emr;
      ex_rt       = ert;
      #1;
      check_all({tag, "/pre"});
      nm = m;
      if (fl) begin
         nm.instr = 0;
         nm.valid = 1'b0;
      end else if (!(st || exp_hazard(m, emr, ert))) begin
         nm.instr = v ? i : 0;
         nm.pc    = p;
         nm.valid = v;
      end
      @(posedge clk);
      m = nm;
      #1;
      check_all({tag, "/post"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset, with stall toggled to see in_ready follow it.
      reset_n = 1'b0; instr_in = 32'h1234_5678; pc_plus4_in = 32'hCAFE_0000;
      in_valid = 1'b1; stall = 1'b0; flush = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd0;
      m = '{instr: 0, pc: 0, valid: 1'b0};
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      stall = 1'b1;
      #1;
      check_all("reset_stall");
      check("reset in_ready const", 32'(in_ready), 32'd0);
      stall = 1'b0;
      #1;
      reset_n = 1'b1;

      // First edge after release performs a normal load: addi $8,$9,-4.
      apply(32'h2128FFFC, 32'h0040_0004, 1, 0, 0, 0, 5'd0, "load_addi");
      check("addi opcode const",    32'(opcode),    32'h08);
      check("addi rs const",        32'(rs),        32'd9);
      check("addi rt const",        32'(rt),        32'd8);
      check("addi immediate const", 32'(immediate), 32'hFFFC);
      check("addi valid const",     32'(valid_out), 32'd1);

      // External stall for three cycles, then the waiting word loads.
      for (int k = 0; k < 3; k++) begin
         apply(32'hDEADBEEF, 32'h0040_0008, 1, 1, 0, 0, 5'd0, "stall");
         check("stall instr const", instr_out, 32'h2128FFFC);
         check("stall in_ready const", 32'(in_ready), 32'd0);
      end
      apply(32'hDEADBEEF, 32'h0040_0008, 1, 0, 0, 0, 5'd0, "stall_release");
      check("released instr const", instr_out, 32'hDEADBEEF);

      // Load-use on add $10,$8,$9.
      apply(32'h01095020, 32'h0040_000C, 1, 0, 0, 0, 5'd0, "load_add");
      apply(32'h1111_1111, 32'h0040_0010, 1, 0, 0, 1, 5'd8, "lu_rt8");
      check("lu_rt8 instr held", instr_out, 32'h01095020);
      apply(32'h1111_1111, 32'h0040_0010, 1, 0, 0, 1, 5'd8, "lu_persist");
      apply(32'h2128FFFC, 32'h0040_0010, 1, 0, 0, 1, 5'd0, "lu_rt0");
      check("lu_rt0 instr const", instr_out, 32'h2128FFFC);
      // addi: rt is a destination, only rs=9 can match.
      apply(32'h2128FFFC, 32'h0040_0014, 1, 0, 0, 1, 5'd8, "lu_addi_rt8");
      apply(32'h2128FFFC, 32'h0040_0014, 1, 0, 0, 1, 5'd9, "lu_addi_rs9");
      check("lu_addi_rs9 stall const", 32'(load_use_stall), 32'd1);

      // Flush beats stall and the active hazard on the same edge.
      apply(32'h2128FFFC, 32'h0040_0018, 1, 1, 1, 1, 5'd9, "flush_prio");
      check("flush instr const", instr_out, 32'h0);
      check("flush lus const",   32'(load_use_stall), 32'd0);

      // Bubble on load.
      apply(32'hFFFFFFFF, 32'h0040_001C, 0, 0, 0, 0, 5'd0, "bubble");
      check("bubble instr const", instr_out, 32'h0);

      // Reset pulsed between edges while a valid instruction is held.
      apply(32'h8D2A_0004, 32'h0040_0020, 1, 0, 0, 0, 5'd0, "pre_reset");
      instr_in = 32'h0000_2020; pc_plus4_in = 32'h0040_0024; in_valid = 1'b1; stall = 1'b1;
      reset_n = 1'b0;
      m = '{instr: 0, pc: 0, valid: 1'b0};
      #1;
      check_all("mid_reset");
      check("mid_reset instr const", instr_out, 32'h0);
      reset_n = 1'b1;
      // Still stalled after release: nothing from before reset reappears.
      apply(32'h0000_2020, 32'h0040_0024, 1, 1, 0, 0, 5'd0, "post_reset_stall");
      apply(32'h0000_2020, 32'h0040_0024, 1, 0, 0, 0, 5'd0, "post_reset_load");
      check("post_reset instr const", instr_out, 32'h0000_2020);

      // Randomized run: small register numbers make hazards frequent.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] w;
         logic [5:0]  op;
         int unsigned sel;
         sel = $urandom_range(0, 6);
         case (sel)
            0: op = 6'h00;
            1: op = 6'h04;
            2: op = 6'h05;
            3: op = 6'h2B;
            4: op = 6'h23;
            5: op = 6'h08;
            default: op = 6'($urandom);
         endcase
         w = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
         apply(w, $urandom, ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
               5'($urandom_range(0, 3)), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
